// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment encodings, converter states and the digit decoder
package seg_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hFD;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        logic [7:0] s;
        case (nibble)
            4'd0:    s = SEG_DIGIT[0];
            4'd1:    s = SEG_DIGIT[1];
            4'd2:    s = SEG_DIGIT[2];
            4'd3:    s = SEG_DIGIT[3];
            4'd4:    s = SEG_DIGIT[4];
            4'd5:    s = SEG_DIGIT[5];
            4'd6:    s = SEG_DIGIT[6];
            4'd7:    s = SEG_DIGIT[7];
            4'd8:    s = SEG_DIGIT[8];
            4'd9:    s = SEG_DIGIT[9];
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 8-bit binary to two BCD digits
// bcd/ovf hold the finished result while done is high; the caller commits it.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd,
    output logic       ovf
);

    conv_state_t state_q;
    logic [7:0]  shadow_q;
    logic [7:0]  scratch_q;
    logic [2:0]  bit_q;
    logic        big_q;
    logic [7:0]  scratch_d;

    // Add-3 correction on each nibble, then shift in the next binary bit.
    always_comb begin
        scratch_d[3:0] = scratch_q[3:0] >= 4'd5 ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
        scratch_d[7:4] = scratch_q[7:4] >= 4'd5 ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
        scratch_d      = {scratch_d[6:0], shadow_q[7]};
    end

    // Conversion FSM: reset lands in LOAD so a result appears without a frame tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LOAD;
            shadow_q  <= 8'h00;
            scratch_q <= 8'h00;
            bit_q     <= 3'd0;
            big_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    shadow_q  <= bin;
                    scratch_q <= 8'h00;
                    bit_q     <= 3'd0;
                    big_q     <= bin > 8'd99;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shadow_q  <= {shadow_q[6:0], 1'b0};
                    bit_q     <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign bcd  = big_q ? 8'h00 : scratch_q;
    assign ovf  = big_q;

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: BCD conversion of the counter value and two-digit 7-segment scan
// Optional feature macro: SEG_BLANK_LEADING_ZERO_EN blanks a zero tens digit.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] value,
    output logic [7:0] seg,
    output logic [1:0] an,
    output logic [7:0] bcd,
    output logic       overflow
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

    logic [DW-1:0] div_q;
    logic          slot_q;
    logic [7:0]    seg_q;
    logic [1:0]    an_q;
    logic [7:0]    bcd_q;
    logic          ovf_q;
    logic          tc;
    logic          frame_tick;
    logic          conv_busy;
    logic          conv_done;
    logic [7:0]    conv_bcd;
    logic          conv_ovf;
    logic [3:0]    digit;
    logic          blank;
    logic [7:0]    seg_d;
    logic [1:0]    an_d;

    assign tc         = div_q == DIV_MAX;
    assign frame_tick = tc & slot_q;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (frame_tick & ~conv_busy),
        .bin     (value),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .ovf     (conv_ovf)
    );

    // Pick the digit for the current slot; overflow forces a dash on both.
    always_comb begin
        digit = slot_q ? bcd_q[7:4] : bcd_q[3:0];
`ifdef SEG_BLANK_LEADING_ZERO_EN
        blank = slot_q && bcd_q[7:4] == 4'd0;
`else
        blank = 1'b0;
`endif
        seg_d = ovf_q ? SEG_DASH : blank ? SEG_BLANK : seg_decode(digit);
        an_d  = slot_q ? 2'b01 : 2'b10;
    end

    // Refresh divider, slot toggle, result commit and registered display outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            slot_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= 2'b11;
            bcd_q  <= 8'h00;
            ovf_q  <= 1'b0;
        end else begin
            div_q  <= tc ? '0 : div_q + 1'b1;
            slot_q <= tc ? ~slot_q : slot_q;
            seg_q  <= seg_d;
            an_q   <= an_d;
            if (conv_done) begin
                bcd_q <= conv_bcd;
                ovf_q <= conv_ovf;
            end
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed vectors and corner sequences for seg_scan_driver
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] value = 8'h00;
    logic [7:0] seg;
    logic [1:0] an;
    logic [7:0] bcd;
    logic       overflow;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

`ifdef SEG_BLANK_LEADING_ZERO_EN
    localparam logic [7:0] TENS0 = 8'hFF;
`else
    localparam logic [7:0] TENS0 = 8'h03;
`endif

    typedef struct {
        logic [7:0] value;
        logic [7:0] bcd;
        logic       ovf;
        logic [7:0] ones;
        logic [7:0] tens;
    } vec_t;

    vec_t vecs [10];

    seg_scan_driver #(.REFRESH_DIV(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .value    (value),
        .seg      (seg),
        .an       (an),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold reset for two cycles and release on a falling edge; edge 1 is the next rise.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    // Advance to the falling edge that follows rising edge k after release.
    task automatic to_edge(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'd47,  8'h47, 1'b0, 8'h1F, 8'h99};
        vecs[1] = '{8'd5,   8'h05, 1'b0, 8'h49, TENS0};
        vecs[2] = '{8'd0,   8'h00, 1'b0, 8'h03, TENS0};
        vecs[3] = '{8'd99,  8'h99, 1'b0, 8'h09, 8'h09};
        vecs[4] = '{8'd100, 8'h00, 1'b1, 8'hFD, 8'hFD};
        vecs[5] = '{8'd255, 8'h00, 1'b1, 8'hFD, 8'hFD};
        vecs[6] = '{8'd10,  8'h10, 1'b0, 8'h03, 8'h9F};
        vecs[7] = '{8'd88,  8'h88, 1'b0, 8'h01, 8'h01};
        vecs[8] = '{8'd63,  8'h63, 1'b0, 8'h0D, 8'h41};
        vecs[9] = '{8'd20,  8'h20, 1'b0, 8'h03, 8'h25};

        // Each vector: value held at release, result at edge 10, ones shown at 11, tens at 20.
        for (int i = 0; i < 10; i++) begin
            value = vecs[i].value;
            do_reset();
            to_edge(9);
            chk($sformatf("v%0d bcd_before", i), bcd, 8'h00);
            to_edge(10);
            chk($sformatf("v%0d bcd", i), bcd, vecs[i].bcd);
            chk($sformatf("v%0d ovf", i), {7'd0, overflow}, {7'd0, vecs[i].ovf});
            to_edge(11);
            chk($sformatf("v%0d an_ones", i), {6'd0, an}, 8'h02);
            chk($sformatf("v%0d seg_ones", i), seg, vecs[i].ones);
            to_edge(20);
            chk($sformatf("v%0d an_tens", i), {6'd0, an}, 8'h01);
            chk($sformatf("v%0d seg_tens", i), seg, vecs[i].tens);
        end

        // Asynchronous reset in the middle of a scan.
        value = 8'd47;
        do_reset();
        to_edge(20);
        #2 reset_n = 1'b0;
        #1;
        chk("async seg", seg, 8'hFF);
        chk("async an", {6'd0, an}, 8'h03);
        chk("async bcd", bcd, 8'h00);
        chk("async ovf", {7'd0, overflow}, 8'h00);

        // 99 then 100 sampled at the next frame's LOAD (edge 33), committed at edge 42.
        value = 8'd99;
        do_reset();
        to_edge(10);
        chk("s3 bcd99", bcd, 8'h99);
        chk("s3 ovf0", {7'd0, overflow}, 8'h00);
        value = 8'd100;
        to_edge(41);
        chk("s3 bcd_hold", bcd, 8'h99);
        to_edge(42);
        chk("s3 bcd00", bcd, 8'h00);
        chk("s3 ovf1", {7'd0, overflow}, 8'h01);
        to_edge(43);
        chk("s3 an_ones", {6'd0, an}, 8'h02);
        chk("s3 seg_ones", seg, 8'hFD);
        to_edge(50);
        chk("s3 an_tens", {6'd0, an}, 8'h01);
        chk("s3 seg_tens", seg, 8'hFD);

        // Value changes two clocks after LOAD: old value kept until the next frame.
        value = 8'd12;
        do_reset();
        to_edge(2);
        value = 8'd34;
        to_edge(10);
        chk("s4 bcd12", bcd, 8'h12);
        to_edge(41);
        chk("s4 bcd12_hold", bcd, 8'h12);
        to_edge(42);
        chk("s4 bcd34", bcd, 8'h34);

        // Reset pulse during SHIFT discards the partial result.
        value = 8'd47;
        do_reset();
        to_edge(5);
        reset_n = 1'b0;
        value = 8'd83;
        #1;
        chk("s6 bcd_rst", bcd, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
        to_edge(9);
        chk("s6 bcd_before", bcd, 8'h00);
        to_edge(10);
        chk("s6 bcd83", bcd, 8'h83);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
